// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss fill engine: state encoding, default
// block geometry and block-offset mask helper.
package cache_fill_fsm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int unsigned DEF_BLK_WORDS = 8;

  // Mask of the byte-offset bits inside one block of blk_bytes bytes.
  function automatic int unsigned offset_mask(input int unsigned blk_bytes);
    return blk_bytes - 1;
  endfunction

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Word counter for the fill engine: enable, synchronous clear (priority over
// enable) and a terminal-count flag at the all-ones value.
module fill_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == '1);

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-handling engine: on a cache miss it requests every word of the block
// from memory, streams returned words into the data array and writes the tag
// with the final word, holding fsm_busy for the whole fill.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int unsigned AWIDTH    = 16,
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned BLK_WORDS = DEF_BLK_WORDS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         miss_detected,
  input  logic [AWIDTH-1:0]            miss_address,
  output logic                         fsm_busy,
  output logic                         mem_req,
  output logic [AWIDTH-1:0]            mem_addr,
  input  logic                         mem_data_valid,
  output logic                         data_wr_en,
  output logic [$clog2(BLK_WORDS)-1:0] data_wr_word,
  output logic                         tag_wr_en,
  output logic                         fill_done
);

  localparam int unsigned CW         = $clog2(BLK_WORDS);
  localparam int unsigned WORD_BYTES = DWIDTH / 8;
  localparam logic [AWIDTH-1:0] OFFSET_MASK =
    AWIDTH'(offset_mask(WORD_BYTES * BLK_WORDS));

  fill_state_t       state;
  fill_state_t       state_next;
  logic              accept;
  logic              req_active;
  logic [AWIDTH-1:0] base;
  logic [CW-1:0]     req_cnt;
  logic [CW-1:0]     rsp_cnt;
  logic              req_tc;
  logic              rsp_tc;

  assign accept = (state == IDLE) && miss_detected;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request side runs on its own flag so responses may overlap the requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base       <= '0;
      req_active <= 1'b0;
    end else if (accept) begin
      base       <= miss_address & ~OFFSET_MASK;
      req_active <= 1'b1;
    end else if (req_active && req_tc) begin
      req_active <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    data_wr_en = 1'b0;
    tag_wr_en  = 1'b0;
    fill_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (miss_detected) state_next = FILL;
      end
      FILL: begin
        if (mem_data_valid) begin
          data_wr_en = 1'b1;
          if (rsp_tc) begin
            tag_wr_en  = 1'b1;
            fill_done  = 1'b1;
            state_next = IDLE;
          end
        end
      end
    endcase
  end

  fill_counter #(.WIDTH(CW)) u_req_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (req_active),
    .clr   (accept),
    .count (req_cnt),
    .tc    (req_tc)
  );

  fill_counter #(.WIDTH(CW)) u_rsp_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (data_wr_en),
    .clr   (accept),
    .count (rsp_cnt),
    .tc    (rsp_tc)
  );

  assign fsm_busy     = (state == FILL);
  assign mem_req      = req_active;
  assign mem_addr     = req_active ? base + (AWIDTH'(WORD_BYTES) * AWIDTH'(req_cnt)) : '0;
  assign data_wr_word = rsp_cnt;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: transaction-level fill model checked every cycle,
// ordered-latency memory model, and literal expectations per scenario.
module tb_cache_fill_fsm;

  localparam int unsigned BLK = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        mem_data_valid;
  logic        fsm_busy, mem_req, data_wr_en, tag_wr_en, fill_done;
  logic [15:0] mem_addr;
  logic [2:0]  data_wr_word;

  cache_fill_fsm #(.AWIDTH(16), .DWIDTH(16), .BLK_WORDS(BLK)) dut (
    .clk            (clk),
    .rst            (rst),
    .miss_detected  (miss_detected),
    .miss_address   (miss_address),
    .fsm_busy       (fsm_busy),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_data_valid (mem_data_valid),
    .data_wr_en     (data_wr_en),
    .data_wr_word   (data_wr_word),
    .tag_wr_en      (tag_wr_en),
    .fill_done      (fill_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        stray = 1'b0;
  int unsigned lat_lo = 4;
  int unsigned lat_hi = 4;

  // Memory: each request answered lat cycles later, strictly in order.
  initial begin : memory
    int unsigned due_q[$];
    int unsigned last_due;
    int unsigned due;
    logic        hit;
    last_due = 0;
    mem_data_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        due_q.delete();
        last_due = 0;
      end else if (mem_req === 1'b1) begin
        due = cyc + $urandom_range(lat_hi, lat_lo);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        due_q.push_back(due);
      end
      @(posedge clk);
      #2;
      hit = (due_q.size() > 0) && (due_q[0] == cyc);
      if (hit) void'(due_q.pop_front());
      mem_data_valid = hit || stray;
    end
  end

  // Fill model: counts of requests issued and words received per fill.
  logic        m_busy = 1'b0;
  logic [15:0] m_base = '0;
  int unsigned m_req = 0;
  int unsigned m_rsp = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0;
      m_base = '0;
      m_req  = 0;
      m_rsp  = 0;
    end else if (!m_busy) begin
      if (miss_detected) begin
        m_busy = 1'b1;
        m_base = miss_address & 16'hFFF0;
        m_req  = 0;
        m_rsp  = 0;
      end
    end else begin
      if (m_req < BLK) m_req = m_req + 1;
      if (mem_data_valid) begin
        if (m_rsp == BLK - 1) m_busy = 1'b0;
        m_rsp = m_rsp + 1;
      end
    end
  end

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } lit_t;
  lit_t lit_q[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [15:0] req_addr_q[$];
  int unsigned req_cyc_q[$];
  int unsigned wr_word_q[$];
  int unsigned wr_cyc_q[$];
  int unsigned tag_cyc_q[$];
  int unsigned fall_cyc_q[$];
  logic        prev_busy = 1'b0;
  int unsigned lit_rd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : compare
    logic        e_req, e_wr, e_tag;
    logic [15:0] e_addr;
    e_req  = m_busy && (m_req < BLK);
    e_wr   = m_busy && mem_data_valid;
    e_tag  = e_wr && (m_rsp == BLK - 1);
    e_addr = rst ? m_base + 16'(2 * m_req) : 16'h0000;
    chk("fsm_busy", 32'(fsm_busy), 32'(m_busy));
    chk("mem_req", 32'(mem_req), 32'(e_req));
    if (e_req || !rst) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("data_wr_en", 32'(data_wr_en), 32'(e_wr));
    if (e_wr || !rst) chk("data_wr_word", 32'(data_wr_word), rst ? m_rsp : 32'd0);
    chk("tag_wr_en", 32'(tag_wr_en), 32'(e_tag));
    chk("fill_done", 32'(fill_done), 32'(e_tag));
    if (mem_req === 1'b1) begin
      req_addr_q.push_back(mem_addr);
      req_cyc_q.push_back(cyc);
    end
    if (data_wr_en === 1'b1) begin
      wr_word_q.push_back(32'(data_wr_word));
      wr_cyc_q.push_back(cyc);
    end
    if (tag_wr_en === 1'b1) tag_cyc_q.push_back(cyc);
    if (prev_busy && fsm_busy === 1'b0) fall_cyc_q.push_back(cyc);
    prev_busy = (fsm_busy === 1'b1);
    while (lit_rd < lit_q.size()) begin
      chk(lit_q[lit_rd].name, lit_q[lit_rd].act, lit_q[lit_rd].exp);
      lit_rd = lit_rd + 1;
    end
  end

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lit_t e;
    e.name = nm;
    e.act  = act;
    e.exp  = exp;
    lit_q.push_back(e);
  endtask

  task automatic wait_busy(input logic level, input int unsigned budget, input string nm);
    int unsigned k;
    k = 0;
    while (fsm_busy !== level && k < budget) begin
      tick();
      k = k + 1;
    end
    if (fsm_busy !== level) expect_lit(nm, 32'(fsm_busy), 32'(level));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int unsigned c0, n0, w0, t0, f0, k;

    // Reset held with a miss pending: nothing may start.
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    tick(3);
    expect_lit("rst_busy", 32'(fsm_busy), 32'd0);
    expect_lit("rst_mem_addr", 32'(mem_addr), 32'd0);
    miss_detected = 1'b0;
    rst = 1'b1;
    tick(2);
    expect_lit("post_rst_req", 32'(mem_req), 32'd0);

    // Basic fill with latency 4.
    n0 = req_addr_q.size(); w0 = wr_word_q.size(); t0 = tag_cyc_q.size(); f0 = fall_cyc_q.size();
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    c0 = cyc;
    tick();
    miss_detected = 1'b0;
    wait_busy(1'b0, 40, "basic_timeout");
    tick(2);
    expect_lit("basic_req_count", req_addr_q.size() - n0, 32'd8);
    expect_lit("basic_first_addr", 32'(req_addr_q[n0]), 32'h1230);
    expect_lit("basic_last_addr", 32'(req_addr_q[n0 + 7]), 32'h123E);
    expect_lit("basic_first_req_cyc", req_cyc_q[n0] - c0, 32'd1);
    expect_lit("basic_first_wr_cyc", wr_cyc_q[w0] - c0, 32'd5);
    expect_lit("basic_last_word", wr_word_q[w0 + 7], 32'd7);
    expect_lit("basic_done_cyc", tag_cyc_q[t0] - c0, 32'd12);
    expect_lit("basic_busy_fall_cyc", fall_cyc_q[f0] - c0, 32'd13);

    // Wrap at the top of the address space.
    n0 = req_addr_q.size();
    miss_detected = 1'b1;
    miss_address  = 16'hFFFA;
    tick();
    miss_detected = 1'b0;
    wait_busy(1'b0, 40, "wrap_timeout");
    tick(2);
    expect_lit("wrap_first_addr", 32'(req_addr_q[n0]), 32'hFFF0);
    expect_lit("wrap_last_addr", 32'(req_addr_q[n0 + 7]), 32'hFFFE);

    // Back-to-back: miss held high; address changes mid-fill must be ignored.
    n0 = req_addr_q.size(); f0 = fall_cyc_q.size();
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    tick();
    miss_address  = 16'h4448;
    tick();
    wait_busy(1'b0, 40, "b2b_fall_timeout");
    wait_busy(1'b1, 5, "b2b_rise_timeout");
    miss_detected = 1'b0;
    wait_busy(1'b0, 40, "b2b_end_timeout");
    tick(2);
    expect_lit("b2b_first_last_addr", 32'(req_addr_q[n0 + 7]), 32'h123E);
    expect_lit("b2b_second_base", 32'(req_addr_q[n0 + 8]), 32'h4440);
    expect_lit("b2b_second_req_cyc", req_cyc_q[n0 + 8] - fall_cyc_q[f0], 32'd1);

    // Irregular latency plus stray valids in IDLE.
    lat_lo = 4; lat_hi = 10;
    w0 = wr_word_q.size(); t0 = tag_cyc_q.size();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick();
    miss_detected = 1'b1;
    miss_address  = 16'h0A5C;
    tick();
    miss_detected = 1'b0;
    wait_busy(1'b0, 200, "irreg_timeout");
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick(2);
    expect_lit("irreg_wr_count", wr_word_q.size() - w0, 32'd8);
    for (int unsigned i = 0; i < BLK; i++) begin
      if (w0 + i < wr_word_q.size()) expect_lit("irreg_word_order", wr_word_q[w0 + i], i);
    end
    expect_lit("irreg_tag_count", tag_cyc_q.size() - t0, 32'd1);
    if (wr_word_q.size() >= w0 + 8 && tag_cyc_q.size() > t0)
      expect_lit("irreg_tag_on_8th", tag_cyc_q[t0], wr_cyc_q[w0 + 7]);
    lat_lo = 4; lat_hi = 4;

    // Reset after the 3rd response abandons the fill.
    w0 = wr_word_q.size(); t0 = tag_cyc_q.size();
    miss_detected = 1'b1;
    miss_address  = 16'h5550;
    tick();
    miss_detected = 1'b0;
    k = 0;
    while (wr_word_q.size() < w0 + 3 && k < 40) begin
      tick();
      k = k + 1;
    end
    if (wr_word_q.size() < w0 + 3) expect_lit("midrst_timeout", wr_word_q.size() - w0, 32'd3);
    rst = 1'b0;
    #2;
    expect_lit("midrst_busy", 32'(fsm_busy), 32'd0);
    expect_lit("midrst_req", 32'(mem_req), 32'd0);
    expect_lit("midrst_wr", 32'(data_wr_en), 32'd0);
    expect_lit("midrst_tag", 32'(tag_wr_en), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(2);
    expect_lit("midrst_no_tag", tag_cyc_q.size() - t0, 32'd0);
    n0 = req_addr_q.size(); w0 = wr_word_q.size();
    miss_detected = 1'b1;
    miss_address  = 16'h2222;
    tick();
    miss_detected = 1'b0;
    wait_busy(1'b0, 40, "restart_timeout");
    tick(2);
    expect_lit("restart_base", 32'(req_addr_q[n0]), 32'h2220);
    expect_lit("restart_first_word", wr_word_q[w0], 32'd0);
    expect_lit("restart_wr_count", wr_word_q.size() - w0, 32'd8);
    expect_lit("restart_tag_count", tag_cyc_q.size() - t0, 32'd1);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
